// File: rtl/sub_bytes_seq_pkg.sv
// Shared AES definitions for the iterative SubBytes engine: byte/state
// typedefs, state geometry, byte slicing helper and the S-box tables.
// Optional macro: SUB_BYTES_SEQ_INV_EN adds the inverse S-box table.
package sub_bytes_seq_pkg;

  localparam int AES_STATE_BYTES = 16;

  typedef logic [7:0]             byte_t;
  typedef logic [0:3][0:3][7:0]   state_t;  // state[k/4][k%4] = byte k, byte 0 in the MSBs

  // LSB position of byte k inside a flat 128-bit state (byte 0 at bits 127:120).
  function automatic int byte_lsb(input int k);
    return 120 - 8 * k;
  endfunction

  localparam byte_t SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef SUB_BYTES_SEQ_INV_EN
  localparam byte_t INV_SBOX_TABLE [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

endpackage

// File: rtl/sub_bytes_seq_sbox.sv
// Combinational AES S-box lookup (lhs -> o), plus the inverse S-box when
// SUB_BYTES_SEQ_INV_EN is defined. Both share the same port shape.
module sbox
  import sub_bytes_seq_pkg::*;
(
  input  logic [7:0] lhs,
  output logic [7:0] o
);
  assign o = SBOX_TABLE[lhs];
endmodule

`ifdef SUB_BYTES_SEQ_INV_EN
module inv_sbox
  import sub_bytes_seq_pkg::*;
(
  input  logic [7:0] lhs,
  output logic [7:0] o
);
  assign o = INV_SBOX_TABLE[lhs];
endmodule
`endif

// File: rtl/sub_bytes_seq.sv
// Iterative SubBytes engine: LANES shared S-boxes walk the 16-byte state in
// 16/LANES cycles. Valid/ready on both sides; outputs decode from FSM state
// and the data register only.
// Optional macro: SUB_BYTES_SEQ_INV_EN adds the inv port and per-lane inv_sbox.
module sub_bytes_seq
  import sub_bytes_seq_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef SUB_BYTES_SEQ_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int STEPS = AES_STATE_BYTES / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t             state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [127:0]     data_q;
  logic             cnt_last;
  int               lane_k   [LANES];
  byte_t            lane_in  [LANES];
  byte_t            lane_out [LANES];
`ifdef SUB_BYTES_SEQ_INV_EN
  logic             inv_q;
`endif

  assign cnt_last  = (cnt_q == CNT_W'(STEPS - 1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = data_q;

  // Lane input mux: lane i reads byte cnt*LANES+i of the data register.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_k[i]  = int'(cnt_q) * LANES + i;
      lane_in[i] = data_q[byte_lsb(lane_k[i]) +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    byte_t fwd;
    sbox u_sbox (.lhs(lane_in[g]), .o(fwd));
`ifdef SUB_BYTES_SEQ_INV_EN
    byte_t bwd;
    inv_sbox u_inv_sbox (.lhs(lane_in[g]), .o(bwd));
    assign lane_out[g] = inv_q ? bwd : fwd;
`else
    assign lane_out[g] = fwd;
`endif
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  // NOTE: default assigned first so no path through the case leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (cnt_last)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, substitute LANES bytes per RUN cycle, step the counter.
  // NOTE: the data register is reset to zero so out_state is defined from reset; it is a flop bank, not a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      data_q <= '0;
`ifdef SUB_BYTES_SEQ_INV_EN
      inv_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_state;
            cnt_q  <= '0;
`ifdef SUB_BYTES_SEQ_INV_EN
            inv_q  <= inv;
`endif
          end
        end
        RUN: begin
          for (int i = 0; i < LANES; i++) begin
            data_q[byte_lsb(lane_k[i]) +: 8] <= lane_out[i];
          end
          cnt_q <= cnt_last ? '0 : cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Self-checking bench for sub_bytes_seq (LANES=4): directed vector table,
// handshake stall, reset abort and a random stream against a reference
// S-box computed from GF(2^8) inversion plus the affine transform.
module tb_sub_bytes_seq;

  localparam int LANES = 4;
  localparam int STEPS = 16 / LANES;
  localparam int NRAND = 300;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
`ifdef SUB_BYTES_SEQ_INV_EN
  logic         inv;
`endif

  sub_bytes_seq #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
`ifdef SUB_BYTES_SEQ_INV_EN
    .inv(inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference S-box built from first principles.
  logic [7:0] ref_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] v = 8'h00;
    for (int c = 1; c < 256; c++) if (gmul(x, 8'(c)) == 8'h01) v = 8'(c);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = ref_tab[x[127-8*k -: 8]];
    return r;
  endfunction

  // Wait for out_valid; edges counts rising edges from the accept edge (inclusive).
  task automatic wait_out(output logic [127:0] d, output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (!out_valid && edges < 64) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      in_valid = 1'b0;
      if (busy) busy_cnt++;
    end
    d = out_state;
  endtask

  task automatic run_block(input logic [127:0] din, output logic [127:0] d,
                           output int edges, output int busy_cnt);
    in_state = din;
    in_valid = 1'b1;
    wait_out(d, edges, busy_cnt);
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d, exp_d, other;
    int lat, bcnt;
    logic ok;
    logic [127:0] exp_q [$];
    int sent, rcvd, cyc;
    logic in_fire, out_fire;
    logic [127:0] obs;

    for (int i = 0; i < 256; i++) ref_tab[i] = ref_sbox(8'(i));

    vecs[0] = '{{16{8'h00}}, {16{8'h63}}};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76};
    vecs[2] = '{{8'h53, {14{8'h00}}, 8'hff}, {8'hed, {14{8'h63}}, 8'h16}};
    vecs[3] = '{128'h101112131415161718191a1b1c1d1e1f, 128'hca82c97dfa5947f0add4a2af9ca472c0};
    vecs[4] = '{{16{8'hff}}, {16{8'h16}}};
    vecs[5] = '{{16{8'h53}}, {16{8'hed}}};
    vecs[6] = '{128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 128'h8ca1890dbfe6426841992d0fb054bb16};

    rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
`ifdef SUB_BYTES_SEQ_INV_EN
    inv = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready",  128'(in_ready),  128'd1);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset busy",      128'(busy),      128'd0);
    check("reset out_state", out_state,       '0);
    rst = 1'b0;

    // Directed vectors with out_ready held high.
    for (int v = 0; v < 7; v++) begin
      run_block(vecs[v].din, d, lat, bcnt);
      check($sformatf("vec%0d out_state", v), d, vecs[v].dout);
      check($sformatf("vec%0d latency", v), 128'(lat), 128'(STEPS + 1));
      if (v == 0) check("vec0 busy cycles", 128'(bcnt), 128'(STEPS + 1));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d back to idle", v), 128'({in_ready, busy, out_valid}), 128'(3'b100));
    end

    // Output stall in DONE with a competing input offered.
    out_ready = 1'b0;
    run_block(vecs[2].din, d, lat, bcnt);
    other = 128'h00112233445566778899aabbccddeeff;
    in_state = other;
    in_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || out_state !== vecs[2].dout || in_ready || !busy) ok = 1'b0;
    end
    check("stall holds output", 128'(ok), 128'd1);
    check("stall out_state", out_state, {8'hed, {14{8'h63}}, 8'h16});
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall release to idle", 128'({in_ready, busy, out_valid}), 128'(3'b100));
    wait_out(d, lat, bcnt);
    check("post-stall block", d, ref_sub(other));
    check("post-stall latency", 128'(lat), 128'(STEPS + 1));
    @(posedge clk);
    @(negedge clk);

    // Reset while RUN at cnt=2 aborts the block.
    in_state = {16{8'h11}};
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("abort state", 128'({in_ready, busy, out_valid}), 128'(3'b100));
    check("abort data cleared", out_state, '0);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid || busy) ok = 1'b0;
    end
    check("abort never output", 128'(ok), 128'd1);
    run_block(vecs[6].din, d, lat, bcnt);
    check("after abort block", d, vecs[6].dout);
    @(posedge clk); @(negedge clk);

`ifdef SUB_BYTES_SEQ_INV_EN
    // Inverse mode with inv toggled mid-RUN.
    inv = 1'b1;
    in_state = {16{8'h63}};
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0; inv = 1'b0;
    @(posedge clk); @(negedge clk); inv = 1'b1;
    @(posedge clk); @(negedge clk); inv = 1'b0;
    wait_out(d, lat, bcnt);
    check("inv block", d, '0);
    @(posedge clk); @(negedge clk);
`endif

    // Random stream with stalls on both sides.
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < NRAND && cyc < 20000) begin
      in_valid  = (sent < NRAND) && ($urandom_range(0, 3) != 0);
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      in_fire   = in_valid && in_ready;
      out_fire  = out_valid && out_ready;
      obs       = out_state;
      @(posedge clk);
      if (in_fire) begin
        exp_q.push_back(ref_sub(in_state));
        sent++;
      end
      if (out_fire) begin
        if (exp_q.size() == 0) check("random unexpected output", obs, 'x);
        else begin
          exp_d = exp_q.pop_front();
          check($sformatf("random block %0d", rcvd), obs, exp_d);
        end
        rcvd++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("random received count", 128'(rcvd), 128'(NRAND));
    check("random queue drained", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
